// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: branch funct3 codes, PC unit states, PC step.
// Imported by the PC/branch unit and its condition decoder.
package rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_TRAP     = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from funct3 and comparator flags.
// Illegal funct3 codes and an idle comparator never take.
module branch_cond
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  input  logic       work,
  input  logic       is_branch,
  output logic       cond_taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:            cond = BrEq;
      F3_BNE:            cond = !BrEq;
      F3_BLT, F3_BLTU:   cond = BrLT;
      F3_BGE, F3_BGEU:   cond = !BrLT;
      default:           cond = 1'b0;
    endcase
  end

  assign cond_taken = is_branch && work && cond;

endmodule

// File: rtl/pc_branch_unit.sv
// Architectural PC owner: branch resolution, redirect flush, trap.
// PC_BRANCH_STATS_EN enables the branch/taken counters.
module pc_branch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        fetch_ready,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic        BrEq,
  input  logic        BrLT,
  input  logic        work,
  input  logic [31:0] imm,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        taken,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] trap_pc_q;
  logic        taken_q;
  logic        trap_q;

  logic        cond_taken;
  logic        accept;
  logic        redirect;
  logic [31:0] target;

  branch_cond u_cond (
    .funct3     (funct3),
    .BrEq       (BrEq),
    .BrLT       (BrLT),
    .work       (work),
    .is_branch  (is_branch),
    .cond_taken (cond_taken)
  );

  assign accept   = (state_q == ST_RUN) && instr_valid && fetch_ready;
  assign redirect = is_jalr || is_jal || cond_taken;

  always_comb begin
    target = pc_q + PC_STEP;
    if (is_jalr)
      target = jalr_target & ~32'h1;
    else if (is_jal || cond_taken)
      target = pc_q + imm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      taken_q   <= 1'b0;
      trap_q    <= 1'b0;
      trap_pc_q <= 32'h0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (!redirect) begin
              pc_q    <= pc_q + PC_STEP;
              taken_q <= 1'b0;
            end else if (target[1:0] == 2'b00) begin
              pc_q    <= target;
              taken_q <= 1'b1;
              state_q <= ST_REDIRECT;
            end else begin
              trap_pc_q <= pc_q;
              trap_q    <= 1'b1;
              state_q   <= ST_TRAP;
            end
          end
        end
        ST_REDIRECT: state_q <= ST_RUN;
        default:     state_q <= ST_TRAP;
      endcase
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] br_tk_q;
  logic        br_acc;

  // jal/jalr win over is_branch, so they are excluded from the stats
  assign br_acc = accept && is_branch && work && !is_jal && !is_jalr;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= 32'h0;
      br_tk_q  <= 32'h0;
    end else if (br_acc) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (cond_taken)
        br_tk_q <= br_tk_q + 32'd1;
    end
  end

  assign br_count       = br_cnt_q;
  assign br_taken_count = br_tk_q;
`else
  assign br_count       = 32'h0;
  assign br_taken_count = 32'h0;
`endif

  assign pc       = pc_q;
  assign pc_valid = (state_q == ST_RUN) && !rst;
  assign taken    = taken_q;
  assign flush    = (state_q == ST_REDIRECT);
  assign trap     = trap_q;
  assign trap_pc  = trap_pc_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed-vector bench for pc_branch_unit (RESET_PC = 0x100).
// Counter checks follow PC_BRANCH_STATS_EN.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        fetch_ready;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic        BrEq;
  logic        BrLT;
  logic        work;
  logic [31:0] imm;
  logic [31:0] jalr_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        taken;
  logic        flush;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] br_count;
  logic [31:0] br_taken_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(.RESET_PC(32'h100)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .fetch_ready    (fetch_ready),
    .is_branch      (is_branch),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .funct3         (funct3),
    .BrEq           (BrEq),
    .BrLT           (BrLT),
    .work           (work),
    .imm            (imm),
    .jalr_target    (jalr_target),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .taken          (taken),
    .flush          (flush),
    .trap           (trap),
    .trap_pc        (trap_pc),
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 0; fetch_ready = 1;
    is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'b000; BrEq = 0; BrLT = 0; work = 0;
    imm = 32'h0; jalr_target = 32'h0;
  endtask

  task automatic br(input logic [2:0] f3, input logic eq,
                    input logic lt, input logic w,
                    input logic [31:0] im);
    idle();
    instr_valid = 1; is_branch = 1;
    funct3 = f3; BrEq = eq; BrLT = lt; work = w; imm = im;
  endtask

  task automatic jal(input logic [31:0] im);
    idle();
    instr_valid = 1; is_jal = 1; imm = im;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step();
    checks++;
    if (pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_pc_valid got=%b exp=0", pc_valid);
    end
    step();
    rst = 0;
    #1;
    checks++;
    if (pc !== 32'h100 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_pc got=%h/%b exp=100/1", pc, pc_valid);
    end
    checks++;
    if ({taken, flush, trap} !== 3'b000 || trap_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b %h exp=000 0",
               taken, flush, trap, trap_pc);
    end
    checks++;
    if (br_count !== 32'h0 || br_taken_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
               br_count, br_taken_count);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h100;
    idle();
    instr_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (pc !== exp_pc || taken !== 1'b0 || flush !== 1'b0) begin
        failures++;
        $display("FAIL seq%0d got=%h/%b/%b exp=%h/0/0",
                 i, pc, taken, flush, exp_pc);
      end
    end
  endtask

  task automatic test_bne_redirect();
    jal(32'h0F4);
    step();
    checks++;
    if (pc !== 32'h200 || taken !== 1'b1) begin
      failures++;
      $display("FAIL jal got=%h/%b exp=200/1", pc, taken);
    end
    idle();
    step();
    br(3'b001, 1'b0, 1'b0, 1'b1, 32'h40);
    step();
    checks++;
    if (pc !== 32'h240 || taken !== 1'b1) begin
      failures++;
      $display("FAIL bne got=%h/%b exp=240/1", pc, taken);
    end
    checks++;
    if (flush !== 1'b1 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL bne_flush got=%b/%b exp=1/0", flush, pc_valid);
    end
    jal(32'h1000);
    step();
    checks++;
    if (pc !== 32'h240 || flush !== 1'b0 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL redirect_ignore got=%h/%b/%b exp=240/0/1",
               pc, flush, pc_valid);
    end
  endtask

  task automatic test_not_taken();
    jal(32'h0C0);
    step();
    idle();
    step();
    br(3'b111, 1'b0, 1'b1, 1'b1, 32'h40);
    step();
    checks++;
    if (pc !== 32'h304 || taken !== 1'b0 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL bgeu_nt got=%h/%b/%b exp=304/0/1",
               pc, taken, pc_valid);
    end
    br(3'b000, 1'b1, 1'b1, 1'b0, 32'h40);
    step();
    checks++;
    if (pc !== 32'h308 || taken !== 1'b0 || flush !== 1'b0) begin
      failures++;
      $display("FAIL nowork got=%h/%b/%b exp=308/0/0", pc, taken, flush);
    end
    br(3'b010, 1'b1, 1'b1, 1'b1, 32'h40);
    step();
    checks++;
    if (pc !== 32'h30C || taken !== 1'b0) begin
      failures++;
      $display("FAIL illegal_f3 got=%h/%b exp=30c/0", pc, taken);
    end
    br(3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF4);
    step();
    checks++;
    if (pc !== 32'h300 || taken !== 1'b1) begin
      failures++;
      $display("FAIL blt_back got=%h/%b exp=300/1", pc, taken);
    end
  endtask

  task automatic test_stall_and_rst();
    idle();
    step();
    jal(32'h40);
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 32'h300 || taken !== 1'b1 || pc_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall%0d got=%h/%b/%b exp=300/1/1",
                 i, pc, taken, pc_valid);
      end
    end
    fetch_ready = 1;
    step();
    idle();
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if (pc !== 32'h100 || flush !== 1'b0 || pc_valid !== 1'b1 ||
        taken !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_redirect got=%h/%b/%b/%b exp=100/0/1/0",
               pc, flush, pc_valid, taken);
    end
  endtask

  task automatic test_stats();
    br(3'b000, 1'b1, 1'b0, 1'b1, 32'h10);
    step();
    idle();
    step();
    br(3'b001, 1'b1, 1'b0, 1'b1, 32'h10);
    step();
    br(3'b100, 1'b0, 1'b0, 1'b1, 32'h10);
    step();
    br(3'b101, 1'b0, 1'b0, 1'b1, 32'h8);
    step();
    idle();
    step();
    br(3'b110, 1'b0, 1'b0, 1'b1, 32'h10);
    step();
    jal(32'h10);
    step();
    idle();
    step();
    checks++;
    if (pc !== 32'h134) begin
      failures++;
      $display("FAIL stats_pc got=%h exp=134", pc);
    end
    checks++;
`ifdef PC_BRANCH_STATS_EN
    if (br_count !== 32'd5 || br_taken_count !== 32'd2) begin
      failures++;
      $display("FAIL stats got=%0d/%0d exp=5/2", br_count, br_taken_count);
    end
`else
    if (br_count !== 32'd0 || br_taken_count !== 32'd0) begin
      failures++;
      $display("FAIL stats_off got=%0d/%0d exp=0/0",
               br_count, br_taken_count);
    end
`endif
  endtask

  task automatic test_jalr_trap();
    idle();
    instr_valid = 1; is_jalr = 1; jalr_target = 32'h1001;
    step();
    checks++;
    if (pc !== 32'h1000 || taken !== 1'b1) begin
      failures++;
      $display("FAIL jalr_align got=%h/%b exp=1000/1", pc, taken);
    end
    idle();
    step();
    instr_valid = 1; is_jalr = 1; jalr_target = 32'h1003;
    step();
    checks++;
    if (trap !== 1'b1 || trap_pc !== 32'h1000 || pc !== 32'h1000 ||
        pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL trap got=%b/%h/%h/%b exp=1/1000/1000/0",
               trap, trap_pc, pc, pc_valid);
    end
    jal(32'h8);
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (trap !== 1'b1 || pc !== 32'h1000 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL trap_sticky got=%b/%h/%b exp=1/1000/0",
               trap, pc, pc_valid);
    end
    idle();
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if (trap !== 1'b0 || trap_pc !== 32'h0 || pc !== 32'h100 ||
        pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL trap_rst got=%b/%h/%h/%b exp=0/0/100/1",
               trap, trap_pc, pc, pc_valid);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_sequential();
    test_bne_redirect();
    test_not_taken();
    test_stall_and_rst();
    test_stats();
    test_jalr_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
